// File: rtl/fifo_pkg.sv
// Shared FIFO package: default address width plus Gray/binary helpers.
// The helpers work on zero-extended 32-bit values, so callers of any width
// up to 32 bits truncate the result back to their own pointer width.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: request, synchronised read pointer in,
// memory strobe/address and status out. OVERFLOW exists only with
// FIFO_WR_OVF_EN defined.
interface fifo_wr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  W_INC;
  logic [ADDR_WIDTH:0]   RQ_GRAY_PTR;
  logic                  W_EN;
  logic [ADDR_WIDTH-1:0] W_ADDR;
  logic [ADDR_WIDTH:0]   W_GRAY_PTR;
  logic                  FULL;
  logic                  ALMOST_FULL;
  logic [ADDR_WIDTH:0]   W_LEVEL;
`ifdef FIFO_WR_OVF_EN
  logic                  OVERFLOW;
`endif

  // Controller side.
  modport master (
    input  W_INC,
    input  RQ_GRAY_PTR,
    output W_EN,
    output W_ADDR,
    output W_GRAY_PTR,
    output FULL,
    output ALMOST_FULL,
    output W_LEVEL
`ifdef FIFO_WR_OVF_EN
    ,
    output OVERFLOW
`endif
  );

  // Producer / memory / synchroniser side.
  modport slave (
    output W_INC,
    output RQ_GRAY_PTR,
    input  W_EN,
    input  W_ADDR,
    input  W_GRAY_PTR,
    input  FULL,
    input  ALMOST_FULL,
    input  W_LEVEL
`ifdef FIFO_WR_OVF_EN
    ,
    input  OVERFLOW
`endif
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter (XOR prefix from the MSB down). Shared with the
// read-side controller.
module fifo_gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit folds in every Gray bit at or above its position.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller (write clock domain only).
// Owns the binary write pointer, publishes a registered Gray pointer and
// derives FULL / ALMOST_FULL / W_LEVEL from the synchronised read pointer.
// Optional: define FIFO_WR_OVF_EN to add the sticky OVERFLOW flag.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic           W_CLK,
  input  logic           W_RST,
  fifo_wr_ctrl_if.master bus
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  // Full when the write pointer equals the read pointer with its two Gray
  // MSBs inverted; for ADDR_WIDTH = 1 that is the whole pointer.
  localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (ADDR_WIDTH - 1);

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wgray_q, wgray_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic [PtrW-1:0] rbin;
  logic            wr_accept;

  fifo_gray2bin #(
    .WIDTH (PtrW)
  ) u_rq_gray2bin (
    .gray_i (bus.RQ_GRAY_PTR),
    .bin_o  (rbin)
  );

  // Next-state: advance pointer on accepted writes, re-evaluate status.
  always_comb begin
    wr_accept = bus.W_INC & ~full_q;
    wbin_d    = wbin_q + PtrW'(wr_accept);
    wgray_d   = PtrW'(bin2gray(32'(wbin_d)));
    full_d    = (wgray_d == (bus.RQ_GRAY_PTR ^ FullMask));
    level_d   = wbin_d - rbin;
    afull_d   = (32'(level_d) >= AFULL_THRESH);
  end

  // Pointer and status registers.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

`ifdef FIFO_WR_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky: any write attempt while full; only reset clears it.
  always_comb begin
    ovf_d = ovf_q | (bus.W_INC & full_q);
  end

  // Overflow register.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.OVERFLOW = ovf_q;
`endif

  // full_q is 0 in reset, so W_EN follows W_INC there; memory must ignore it.
  assign bus.W_EN        = bus.W_INC & ~full_q;
  assign bus.W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
  assign bus.W_GRAY_PTR  = wgray_q;
  assign bus.FULL        = full_q;
  assign bus.ALMOST_FULL = afull_q;
  assign bus.W_LEVEL     = level_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6).
// Expected register values are queued when a step is driven and popped
// after the clock edge that should produce them.
module tb_fifo_wr_ctrl;

  logic W_CLK = 1'b0;
  logic W_RST = 1'b0;

  always #5 W_CLK = ~W_CLK;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(3)) bus ();

  fifo_wr_ctrl #(
    .ADDR_WIDTH   (3),
    .AFULL_THRESH (6)
  ) dut (
    .W_CLK (W_CLK),
    .W_RST (W_RST),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] gray;
    logic [3:0] level;
    logic       full;
    logic       afull;
    logic [2:0] addr;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0] m_wbin;
  logic       m_full;
  logic       m_ovf;
  logic [3:0] prev_gray;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic logic [3:0] to_bin(input logic [3:0] x);
    logic [3:0] b;
    b[3] = x[3];
    b[2] = b[3] ^ x[2];
    b[1] = b[2] ^ x[1];
    b[0] = b[1] ^ x[0];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write-clock cycle: drive, check combinational outputs, then check
  // the registered outputs after the edge against the queued expectation.
  task automatic step(input logic inc, input logic [3:0] rq);
    exp_t       e;
    logic       acc;
    logic [3:0] nb;
    logic [3:0] lvl;
    @(negedge W_CLK);
    bus.W_INC       = inc;
    bus.RQ_GRAY_PTR = rq;
    #1;
    chk("w_en", 32'(bus.W_EN), 32'(inc & ~m_full));
    chk("w_addr_pre", 32'(bus.W_ADDR), 32'(m_wbin[2:0]));
    acc     = inc & ~m_full;
    nb      = m_wbin + {3'b000, acc};
    lvl     = nb - to_bin(rq);
    e.gray  = to_gray(nb);
    e.level = lvl;
    e.full  = (lvl == 4'd8);
    e.afull = (lvl >= 4'd6);
    e.addr  = nb[2:0];
    e.ovf   = m_ovf | (inc & m_full);
    sb.push_back(e);
    @(posedge W_CLK);
    #1;
    e = sb.pop_front();
    chk("w_gray_ptr", 32'(bus.W_GRAY_PTR), 32'(e.gray));
    chk("w_level", 32'(bus.W_LEVEL), 32'(e.level));
    chk("full", 32'(bus.FULL), 32'(e.full));
    chk("almost_full", 32'(bus.ALMOST_FULL), 32'(e.afull));
    chk("w_addr", 32'(bus.W_ADDR), 32'(e.addr));
`ifdef FIFO_WR_OVF_EN
    chk("overflow", 32'(bus.OVERFLOW), 32'(e.ovf));
`endif
    m_wbin = nb;
    m_full = e.full;
    m_ovf  = e.ovf;
  endtask

  task automatic do_reset();
    @(negedge W_CLK);
    bus.W_INC = 1'b1;
    #2;
    W_RST = 1'b0;
    #1;
    chk("rst_gray", 32'(bus.W_GRAY_PTR), 32'h0);
    chk("rst_level", 32'(bus.W_LEVEL), 32'h0);
    chk("rst_full", 32'(bus.FULL), 32'h0);
    chk("rst_afull", 32'(bus.ALMOST_FULL), 32'h0);
    chk("rst_addr", 32'(bus.W_ADDR), 32'h0);
    chk("rst_w_en", 32'(bus.W_EN), 32'h1);
`ifdef FIFO_WR_OVF_EN
    chk("rst_overflow", 32'(bus.OVERFLOW), 32'h0);
`endif
    m_wbin = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    @(negedge W_CLK);
    bus.W_INC       = 1'b0;
    bus.RQ_GRAY_PTR = '0;
    W_RST           = 1'b1;
    #1;
    chk("post_rst_addr", 32'(bus.W_ADDR), 32'h0);
    chk("post_rst_gray", 32'(bus.W_GRAY_PTR), 32'h0);
  endtask

  initial begin
    bus.W_INC       = 1'b0;
    bus.RQ_GRAY_PTR = '0;
    m_wbin          = '0;
    m_full          = 1'b0;
    m_ovf           = 1'b0;
    #1;
    chk("init_full", 32'(bus.FULL), 32'h0);
    chk("init_level", 32'(bus.W_LEVEL), 32'h0);
    bus.W_INC = 1'b1;
    #1;
    chk("init_w_en", 32'(bus.W_EN), 32'h1);
    bus.W_INC = 1'b0;
    @(negedge W_CLK);
    W_RST = 1'b1;

    // Fill from empty.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b0000);
      if (i == 4) chk("afull_before_6th", 32'(bus.ALMOST_FULL), 32'h0);
      if (i == 5) chk("afull_after_6th", 32'(bus.ALMOST_FULL), 32'h1);
      if (i == 6) chk("full_before_8th", 32'(bus.FULL), 32'h0);
    end
    chk("fill_full", 32'(bus.FULL), 32'h1);
    chk("fill_level", 32'(bus.W_LEVEL), 32'h8);
    chk("fill_gray", 32'(bus.W_GRAY_PTR), 32'hC);

    // Write while full is dropped.
    step(1'b1, 4'b0000);
    chk("ovf_addr_hold", 32'(bus.W_ADDR), 32'h0);
    chk("ovf_gray_hold", 32'(bus.W_GRAY_PTR), 32'hC);
`ifdef FIFO_WR_OVF_EN
    chk("ovf_set", 32'(bus.OVERFLOW), 32'h1);
`endif

    // Read pointer advances by one: FULL drops, one more write refills.
    step(1'b0, 4'b0001);
    chk("drain_full", 32'(bus.FULL), 32'h0);
    chk("drain_level", 32'(bus.W_LEVEL), 32'h7);
    step(1'b1, 4'b0001);
    chk("refill_full", 32'(bus.FULL), 32'h1);
`ifdef FIFO_WR_OVF_EN
    chk("ovf_sticky", 32'(bus.OVERFLOW), 32'h1);
`endif

    // Reset asserted asynchronously mid-burst.
    step(1'b0, 4'b0011);
    step(1'b1, 4'b0011);
    do_reset();

    // Wrap: read pointer trails so the level settles at 2 every cycle.
    prev_gray = bus.W_GRAY_PTR;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, to_gray(m_wbin - 4'd1));
      chk("gray_one_bit", 32'($countones(bus.W_GRAY_PTR ^ prev_gray)), 32'd1);
      prev_gray = bus.W_GRAY_PTR;
    end
    chk("wrap_level", 32'(bus.W_LEVEL), 32'h2);

    // Simultaneous write and read-pointer advance at level 5.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000);
    chk("sim_level_before", 32'(bus.W_LEVEL), 32'h5);
    step(1'b1, to_gray(4'd1));
    chk("sim_level", 32'(bus.W_LEVEL), 32'h5);
    chk("sim_afull", 32'(bus.ALMOST_FULL), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
